// File: rtl/shift_add_mult_ctrl.sv
// Sequencing controller for a 4-bit shift-add multiplier datapath.
// Issues LOAD/ADD/SHIFT pulses under a start/done four-phase handshake.
module shift_add_mult_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  input  logic             i_START,
  input  logic             i_LSB,
  output logic             o_LOAD_cmd,
  output logic             o_ADD_cmd,
  output logic             o_SHIFT_cmd,
  output logic             o_BUSY,
  output logic             o_DONE,
  output logic [CNT_W-1:0] o_BIT_CNT
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_TEST  = 3'd2,
    ST_ADD   = 3'd3,
    ST_SHIFT = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             load_r;
  logic             add_r;
  logic             shift_r;
  logic             busy_r;
  logic             done_r;

  // Next-state and shift-counter decode
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        cnt_next_s = '0;
        if (i_START) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        cnt_next_s   = '0;
        state_next_s = ST_TEST;
      end
      ST_TEST: begin
        if (i_LSB) begin
          state_next_s = ST_ADD;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_ADD: begin
        state_next_s = ST_SHIFT;
      end
      ST_SHIFT: begin
        cnt_next_s = cnt_r + CNT_ONE;
        if ((cnt_r + CNT_ONE) == CNT_LAST) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_TEST;
        end
      end
      ST_DONE: begin
        cnt_next_s = CNT_LAST;
        // Leaving DONE needs START low, so a held START never re-runs
        if (!i_START) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // State, counter and outputs registered from the upcoming state
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      load_r  <= 1'b0;
      add_r   <= 1'b0;
      shift_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      load_r  <= (state_next_s == ST_LOAD);
      add_r   <= (state_next_s == ST_ADD);
      shift_r <= (state_next_s == ST_SHIFT);
      busy_r  <= (state_next_s != ST_IDLE) && (state_next_s != ST_DONE);
      done_r  <= (state_next_s == ST_DONE);
    end
  end

  assign o_LOAD_cmd  = load_r;
  assign o_ADD_cmd   = add_r;
  assign o_SHIFT_cmd = shift_r;
  assign o_BUSY      = busy_r;
  assign o_DONE      = done_r;
  assign o_BIT_CNT   = cnt_r;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl: table of multiplies against a small
// accumulator model, plus reset, handshake and mid-operation reset sequences.
module tb_shift_add_mult_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             lsb;
  logic             load;
  logic             add;
  logic             shift;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bit_cnt;

  logic [3:0] op_a = 4'd0;
  logic [3:0] op_b = 4'd0;
  logic [7:0] acc  = 8'd0;
  logic       arm  = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] res;
    int         lat;
    string      trace;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  shift_add_mult_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .i_CLK       (clk),
    .i_RESET     (rst),
    .i_START     (start),
    .i_LSB       (lsb),
    .o_LOAD_cmd  (load),
    .o_ADD_cmd   (add),
    .o_SHIFT_cmd (shift),
    .o_BUSY      (busy),
    .o_DONE      (done),
    .o_BIT_CNT   (bit_cnt)
  );

  function automatic logic [7:0] shift_step(input logic [7:0] a_in, input logic armed,
                                            input logic [3:0] mcand);
    logic [4:0] sum;
    logic [8:0] wide;
    sum  = {1'b0, a_in[7:4]} + (armed ? {1'b0, mcand} : 5'd0);
    wide = {sum, a_in[3:0]} >> 1;
    return wide[7:0];
  endfunction

  // Datapath model: accumulator/result register driven by the command pulses
  always @(posedge clk) begin
    if (load) begin
      acc <= {4'd0, op_b};
      arm <= 1'b0;
    end else if (add) begin
      arm <= 1'b1;
    end else if (shift) begin
      acc <= shift_step(acc, arm, op_a);
      arm <= 1'b0;
    end
  end

  assign lsb = acc[0];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  // Runs one multiply from the current negedge; leaves START high in DONE
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, output string trace,
                        output int lat, output logic [7:0] res, output int excl_bad,
                        output int busy_bad);
    bit seen;
    op_a = a;
    op_b = b;
    start = 1'b1;
    trace = "";
    lat = 0;
    res = 8'd0;
    excl_bad = 0;
    busy_bad = 0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (load) begin
        seen = 1'b1;
        break;
      end
    end
    chk("load_seen", int'(seen), 1);
    if (!seen) return;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (int'(load) + int'(add) + int'(shift) > 1) excl_bad++;
      if (!busy) busy_bad++;
      if (load) trace = {trace, "L"};
      else if (add) trace = {trace, "A"};
      else if (shift) trace = {trace, "S"};
      else trace = {trace, "T"};
      @(negedge clk);
      lat++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", int'(seen), 1);
    res = acc;
  endtask

  initial begin
    string      trace;
    int         lat;
    int         excl_bad;
    int         busy_bad;
    int         loads;
    int         adds;
    logic [7:0] res;
    bit         seen;

    vecs[0] = '{4'd13, 4'd11, 8'h8F, 12, "LTASTASTSTAS"};
    vecs[1] = '{4'd15, 4'd0,  8'h00, 9,  "LTSTSTSTS"};
    vecs[2] = '{4'd15, 4'd15, 8'hE1, 13, "LTASTASTASTAS"};
    vecs[3] = '{4'd3,  4'd5,  8'h0F, 11, "LTASTSTASTS"};
    vecs[4] = '{4'd0,  4'd9,  8'h00, 11, "LTASTSTSTAS"};
    vecs[5] = '{4'd15, 4'd1,  8'h0F, 10, "LTASTSTSTS"};
    vecs[6] = '{4'd7,  4'd6,  8'h2A, 11, "LTSTASTASTS"};

    // Reset held with START high: everything quiet, LOAD one cycle after release
    rst = 1'b1;
    start = 1'b1;
    op_a = 4'd13;
    op_b = 4'd11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_outputs", {28'd0, load, add, shift, busy, done}, 0);
      chk("rst_bit_cnt", int'(bit_cnt), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_load", int'(load), 1);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_op_done", int'(seen), 1);
    start = 1'b0;
    @(negedge clk);
    chk("rst_op_idle", int'(done), 0);

    // Table of multiplies, each started right after one IDLE cycle
    foreach (vecs[k]) begin
      run_op(vecs[k].a, vecs[k].b, trace, lat, res, excl_bad, busy_bad);
      chk_str("trace", trace, vecs[k].trace);
      chk("latency", lat, vecs[k].lat);
      chk("result", int'(res), int'(vecs[k].res));
      chk("exclusive_cmds", excl_bad, 0);
      chk("busy_during_op", busy_bad, 0);
      chk("done_bit_cnt", int'(bit_cnt), WIDTH);
      chk("done_busy_low", int'(busy), 0);
      start = 1'b0;
      @(negedge clk);
      chk("idle_after_done", {30'd0, done, busy}, 0);
    end

    // Handshake: START held high in DONE must not rerun
    run_op(4'd2, 4'd3, trace, lat, res, excl_bad, busy_bad);
    chk("hs_result", int'(res), 6);
    loads = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (load || !done) loads++;
    end
    chk("hs_no_rerun", loads, 0);
    start = 1'b0;
    @(negedge clk);
    chk("hs_idle", {29'd0, load, done, busy}, 0);
    start = 1'b1;
    @(negedge clk);
    chk("hs_new_load", int'(load), 1);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("hs_second_done", int'(seen), 1);
    start = 1'b0;
    @(negedge clk);

    // Reset during the second ADD of B=11, then a clean restart
    op_a = 4'd13;
    op_b = 4'd11;
    start = 1'b1;
    adds = 0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (add) adds++;
      if (adds == 2) begin
        seen = 1'b1;
        break;
      end
    end
    chk("mid_second_add", int'(seen), 1);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("mid_rst_outputs", {27'd0, load, add, shift, busy, done}, 0);
    chk("mid_rst_bit_cnt", int'(bit_cnt), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_stays_idle", {28'd0, load, add, shift, busy, done}, 0);
    run_op(4'd3, 4'd5, trace, lat, res, excl_bad, busy_bad);
    chk_str("restart_trace", trace, "LTASTSTASTS");
    chk("restart_latency", lat, 11);
    chk("restart_result", int'(res), 15);
    start = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_add_mult_ctrl.md
Name: shift_add_mult_ctrl

Overview:
- Sequencing controller for the 4-bit shift-add multiplier datapath (accumulator/result register plus 4-bit adder).
- Uses a start/done handshake with the requester.
- Issues one-cycle LOAD, ADD and SHIFT command pulses to the result register.
- Bases each add decision on the accumulator LSB fed back from the datapath, and counts shifts until all multiplier bits have been processed.

Parameters:
- WIDTH, 4, number of multiplier bits (equals the number of SHIFT operations per multiply).
- CNT_W, $clog2(WIDTH+1), width of the shift counter.

Ports:
- i_CLK  input  1  system clock; all logic on the rising edge.
- i_RESET  input  1  synchronous reset, active-high.
- i_START  input  1  request to start a multiply; level, four-phase handshake with o_DONE.
- i_LSB  input  1  accumulator bit 0 from the result register.
- o_LOAD_cmd  output  1  load multiplier B into the accumulator; one-cycle pulse.
- o_ADD_cmd  output  1  arm the adder-capture flag in the datapath; one-cycle pulse.
- o_SHIFT_cmd  output  1  shift the accumulator right by 1 (with adder result if armed); one-cycle pulse.
- o_BUSY  output  1  high in every state except IDLE and DONE.
- o_DONE  output  1  result valid in the datapath; held until the handshake completes.
- o_BIT_CNT  output  CNT_W  number of SHIFTs issued in the current operation.

Behaviour:
- Reset (i_RESET=1 at an edge):
  - State becomes IDLE; counter becomes 0.
  - All outputs are 0 from the next cycle onward.
  - Reset has priority over every other event, including mid-operation.
  - The controller does not clear the datapath; the datapath keeps its own reset.
- All outputs are registered, or decoded from registered state only. There is no combinational path from i_START or i_LSB to any output.
- States: IDLE, LOAD, TEST, ADD, SHIFT, DONE.
- IDLE:
  - All commands 0; counter holds 0.
  - If i_START=1, go to LOAD.
- LOAD:
  - o_LOAD_cmd=1 for exactly one cycle; counter cleared to 0.
  - Go to TEST.
- TEST:
  - No command asserted.
  - Sample i_LSB, which is valid because the accumulator updated at the previous edge.
  - i_LSB=1: go to ADD. i_LSB=0: go to SHIFT.
- ADD:
  - o_ADD_cmd=1 for one cycle; go to SHIFT.
  - The datapath captures the flag, and the following SHIFT consumes the adder output.
- SHIFT:
  - o_SHIFT_cmd=1 for one cycle; counter increments.
  - If the counter value after increment equals WIDTH, go to DONE; otherwise go to TEST.
- DONE:
  - o_DONE=1, o_BUSY=0, counter holds WIDTH.
  - Stay until i_START=0 is sampled, then go to IDLE.
  - i_START held high never causes a re-run.
- Exclusivity:
  - At most one of LOAD/ADD/SHIFT is high in any cycle.
  - ADD is always followed immediately by SHIFT.
  - SHIFT is never followed directly by ADD; a TEST cycle always intervenes.
- i_START changes while o_BUSY=1 are ignored.
- i_LSB is ignored outside TEST.
- Latency:
  - o_LOAD_cmd rises 1 cycle after i_START is first sampled high in IDLE.
  - o_DONE rises 1 + 2*WIDTH + popcount(B) cycles after o_LOAD_cmd rises.
  - Minimum is 9 cycles (B=0) and maximum is 13 cycles (B=1111) for WIDTH=4.
- Back-to-back operations: the minimum gap is one IDLE cycle. That is i_START low sampled in DONE, then IDLE, then i_START high sampled, then LOAD.
- Reset asserted mid-operation: the next cycle is IDLE with no command pulse. A subsequent i_START performs a full LOAD.
- Undefined state encodings recover to IDLE on the next edge.

Test Plan:
1. Reset check: hold i_RESET=1 for 3 cycles with i_START=1, then release → all outputs 0 during reset. o_LOAD_cmd pulses exactly one cycle after release (i_START still high).
2. A=13, B=11 with the datapath model attached → command trace LOAD,T,A,S,T,A,S,T,S,T,A,S. o_DONE rises 12 cycles after LOAD; mult_result=143 (8'h8F); 3 ADD and 4 SHIFT pulses.
3. B=0 (A=15) → no o_ADD_cmd pulses. o_DONE at LOAD+9; result 0.
4. B=15, A=15 → ADD before every SHIFT. o_DONE at LOAD+13; result 225 (8'hE1); o_BIT_CNT=4 in DONE.
5. Handshake: keep i_START=1 for 20 cycles after DONE → no second LOAD. Drop i_START for 1 cycle, then raise it → a new LOAD 1 cycle after the rise is sampled.
6. Assert i_RESET during the second ADD of B=11 → next cycle IDLE with all commands 0. Restart A=3, B=5 → result 15, o_DONE at LOAD+11.
